// File: rtl/cpu_lsu_pkg.sv
// Shared size encodings, FSM state type and alignment helper for the load/store unit.
package cpu_lsu_pkg;

   localparam logic [1:0] SZ_B = 2'd0;
   localparam logic [1:0] SZ_H = 2'd1;
   localparam logic [1:0] SZ_W = 2'd2;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_READ  = 3'd1,
      ST_MERGE = 3'd2,
      ST_WRITE = 3'd3,
      ST_RESP  = 3'd4,
      ST_IO    = 3'd5
   } state_t;

   function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] a);
      return ((size == SZ_H) && a[0]) || ((size == SZ_W) && (a != 2'b00));
   endfunction

endpackage

// File: rtl/cpu_lsu_align.sv
// Combinational lane logic: extract/extend a load from a word, splice a sub-word store into a word.
// No latency, no handshake.
module cpu_lsu_align
   import cpu_lsu_pkg::*;
(
   input  logic [31:0] i_word,
   input  logic [31:0] i_wdata,
   input  logic [1:0]  i_lane,
   input  logic [1:0]  i_size,
   input  logic        i_unsigned,
   output logic [31:0] o_ld_data,
   output logic [31:0] o_st_word
);

   logic [7:0]  w_byte;
   logic [15:0] w_half;
   logic [4:0]  w_shift;
   logic [31:0] w_mask;

   always_comb begin
      case (i_lane)
         2'd0:    w_byte = i_word[7:0];
         2'd1:    w_byte = i_word[15:8];
         2'd2:    w_byte = i_word[23:16];
         default: w_byte = i_word[31:24];
      endcase
      w_half    = i_lane[1] ? i_word[31:16] : i_word[15:0];
      w_shift   = (i_size == SZ_H) ? {i_lane[1], 4'b0000} : {i_lane, 3'b000};
      w_mask    = 32'hFFFF_FFFF;
      o_ld_data = i_word;
      case (i_size)
         SZ_B: begin
            w_mask    = 32'h0000_00FF;
            o_ld_data = {{24{~i_unsigned & w_byte[7]}}, w_byte};
         end
         SZ_H: begin
            w_mask    = 32'h0000_FFFF;
            o_ld_data = {{16{~i_unsigned & w_half[15]}}, w_half};
         end
         default: ;
      endcase
      // The RAM has no byte enables, so untouched lanes come from the word just read.
      o_st_word = (i_word & ~(w_mask << w_shift)) | ((i_wdata & w_mask) << w_shift);
   end

endmodule

// File: rtl/cpu_lsu.sv
// Load/store unit to a word-wide sync RAM; resp at T+1 (error), T+2 (word store), T+3 (load), T+4 (sub-word RMW store).
// req_ready high only in IDLE, CPU stalls otherwise; CPU_LSU_MMIO_EN adds an io_* port (held until io_ready) at/above MMIO_BASE.
module cpu_lsu
   import cpu_lsu_pkg::*;
#(
   parameter logic [31:0] BASE_ADDR = 32'h1000_0000,
   parameter int          MEM_AW    = 14,
   parameter logic [31:0] MMIO_BASE = 32'hFFFF_0000
)(
   input  logic              clk,
   input  logic              rst,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_we,
   input  logic [1:0]        req_size,
   input  logic              req_unsigned,
   input  logic [31:0]       req_addr,
   input  logic [31:0]       req_wdata,
   output logic              resp_valid,
   output logic              resp_err,
   output logic [31:0]       resp_rdata,
   output logic              mem_en,
   output logic              mem_we,
   output logic [MEM_AW-1:0] mem_addr,
   output logic [31:0]       mem_wdata,
   input  logic [31:0]       mem_rdata
`ifdef CPU_LSU_MMIO_EN
   ,
   output logic              io_valid,
   input  logic              io_ready,
   output logic              io_we,
   output logic [31:0]       io_addr,
   output logic [31:0]       io_wdata,
   input  logic [31:0]       io_rdata
`endif
);

   state_t            r_state;
   logic              r_req_ready, r_resp_valid, r_resp_err;
   logic              r_mem_en, r_mem_we;
   logic              r_we, r_unsigned;
   logic [1:0]        r_size;
   logic [MEM_AW+1:0] r_off;
   logic [31:0]       r_wdata, r_rdata, r_mem_wdata;

   logic [31:0]       w_off, w_ld_word, w_ld_data, w_st_word;
   logic [1:0]        w_lane;
   logic              w_is_io, w_oor, w_err;

   assign w_off   = req_addr - BASE_ADDR;
   assign w_is_io = (req_addr >= MMIO_BASE);

`ifdef CPU_LSU_MMIO_EN
   logic        r_io_valid;
   logic [31:0] r_io_addr;

   assign w_oor     = !w_is_io && ((w_off >> (MEM_AW + 2)) != 32'd0);
   assign w_ld_word = (r_state == ST_IO) ? io_rdata : mem_rdata;
   assign w_lane    = (r_state == ST_IO) ? r_io_addr[1:0] : r_off[1:0];
   assign io_valid  = r_io_valid;
   assign io_we     = r_we;
   assign io_addr   = r_io_addr;
   assign io_wdata  = r_wdata;
`else
   assign w_oor     = w_is_io || ((w_off >> (MEM_AW + 2)) != 32'd0);
   assign w_ld_word = mem_rdata;
   assign w_lane    = r_off[1:0];
`endif

   assign w_err = (req_size == 2'd3) || is_misaligned(req_size, req_addr[1:0]) || w_oor;

   cpu_lsu_align u_align (
      .i_word     (w_ld_word),
      .i_wdata    (r_wdata),
      .i_lane     (w_lane),
      .i_size     (r_size),
      .i_unsigned (r_unsigned),
      .o_ld_data  (w_ld_data),
      .o_st_word  (w_st_word)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state      <= ST_IDLE;
         r_req_ready  <= 1'b1;
         r_resp_valid <= 1'b0;
         r_resp_err   <= 1'b0;
         r_rdata      <= '0;
         r_mem_en     <= 1'b0;
         r_mem_we     <= 1'b0;
         r_mem_wdata  <= '0;
         r_we         <= 1'b0;
         r_size       <= SZ_B;
         r_unsigned   <= 1'b0;
         r_off        <= '0;
         r_wdata      <= '0;
`ifdef CPU_LSU_MMIO_EN
         r_io_valid   <= 1'b0;
         r_io_addr    <= '0;
`endif
      end else begin
         r_resp_valid <= 1'b0;
         r_resp_err   <= 1'b0;
         r_mem_en     <= 1'b0;
         r_mem_we     <= 1'b0;
         case (r_state)
            ST_IDLE: if (req_valid) begin
               r_we        <= req_we;
               r_size      <= req_size;
               r_unsigned  <= req_unsigned;
               r_off       <= w_off[MEM_AW+1:0];
               r_wdata     <= req_wdata;
               r_rdata     <= '0;
               r_req_ready <= 1'b0;
`ifdef CPU_LSU_MMIO_EN
               r_io_addr   <= req_addr;
`endif
               if (w_err) begin
                  r_state      <= ST_RESP;
                  r_resp_valid <= 1'b1;
                  r_resp_err   <= 1'b1;
`ifdef CPU_LSU_MMIO_EN
               end else if (w_is_io) begin
                  r_state    <= ST_IO;
                  r_io_valid <= 1'b1;
`endif
               end else if (req_we && (req_size == SZ_W)) begin
                  r_state     <= ST_WRITE;
                  r_mem_en    <= 1'b1;
                  r_mem_we    <= 1'b1;
                  r_mem_wdata <= req_wdata;
               end else begin
                  r_state  <= ST_READ;
                  r_mem_en <= 1'b1;
               end
            end
            ST_READ: r_state <= ST_MERGE;
            ST_MERGE: begin
               if (r_we) begin
                  r_state     <= ST_WRITE;
                  r_mem_en    <= 1'b1;
                  r_mem_we    <= 1'b1;
                  r_mem_wdata <= w_st_word;
               end else begin
                  r_state      <= ST_RESP;
                  r_resp_valid <= 1'b1;
                  r_rdata      <= w_ld_data;
               end
            end
            ST_WRITE: begin
               r_state      <= ST_RESP;
               r_resp_valid <= 1'b1;
            end
            ST_RESP: begin
               r_state     <= ST_IDLE;
               r_req_ready <= 1'b1;
            end
`ifdef CPU_LSU_MMIO_EN
            ST_IO: if (io_ready) begin
               r_io_valid   <= 1'b0;
               r_state      <= ST_RESP;
               r_resp_valid <= 1'b1;
               if (!r_we) r_rdata <= w_ld_data;
            end
`endif
            default: begin
               r_state     <= ST_IDLE;
               r_req_ready <= 1'b1;
            end
         endcase
      end
   end

   assign req_ready  = r_req_ready;
   assign resp_valid = r_resp_valid;
   assign resp_err   = r_resp_err;
   assign resp_rdata = r_rdata;
   assign mem_en     = r_mem_en;
   assign mem_we     = r_mem_we;
   assign mem_addr   = r_off[MEM_AW+1:2];
   assign mem_wdata  = r_mem_wdata;

endmodule

// File: tb/tb_cpu_lsu.sv
// Bench for cpu_lsu: vector table, hand-written RMW/reset/MMIO sequences, random ops against a byte-level memory model.
module tb_cpu_lsu;

   localparam logic [31:0] BASE      = 32'h1000_0000;
   localparam int          AW        = 14;
   localparam logic [31:0] RAM_BYTES = 32'd4 << AW;

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic          req_valid = 1'b0, req_we = 1'b0, req_unsigned = 1'b0;
   logic [1:0]    req_size = 2'd0;
   logic [31:0]   req_addr = '0, req_wdata = '0;
   logic          req_ready, resp_valid, resp_err, mem_en, mem_we;
   logic [31:0]   resp_rdata, mem_wdata;
   logic [31:0]   mem_rdata = '0;
   logic [AW-1:0] mem_addr;
`ifdef CPU_LSU_MMIO_EN
   logic          io_valid, io_we;
   logic          io_ready = 1'b1;
   logic [31:0]   io_addr, io_wdata;
   logic [31:0]   io_rdata = '0;
`endif

   always #5 clk = ~clk;

   cpu_lsu #(.BASE_ADDR(BASE), .MEM_AW(AW), .MMIO_BASE(32'hFFFF_0000)) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we), .req_size(req_size),
      .req_unsigned(req_unsigned), .req_addr(req_addr), .req_wdata(req_wdata),
      .resp_valid(resp_valid), .resp_err(resp_err), .resp_rdata(resp_rdata),
      .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata)
`ifdef CPU_LSU_MMIO_EN
      , .io_valid(io_valid), .io_ready(io_ready), .io_we(io_we), .io_addr(io_addr),
      .io_wdata(io_wdata), .io_rdata(io_rdata)
`endif
   );

   // Synchronous RAM with one-cycle read latency, plus access counters.
   logic [31:0] ram [0:(1<<AW)-1];
   int          rd_cnt = 0, wr_cnt = 0, en_cnt = 0;
   logic [31:0] last_wr = '0;
   always @(posedge clk) begin
      if (mem_en) begin
         en_cnt++;
         if (mem_we) begin
            ram[mem_addr] <= mem_wdata;
            last_wr       <= mem_wdata;
            wr_cnt++;
         end else begin
            mem_rdata <= ram[mem_addr];
            rd_cnt++;
         end
      end
   end

   int n_tests = 0, n_fail = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Reference model: RAM as a sparse byte array indexed by offset from BASE.
   logic [7:0] mref [logic [31:0]];

   function automatic logic [7:0] mbyte(input logic [31:0] k);
      return mref.exists(k) ? mref[k] : 8'h00;
   endfunction

   function automatic void model_op(input logic we, input logic [1:0] sz, input logic uns,
                                    input logic [31:0] a, input logic [31:0] wd,
                                    output logic e, output logic [31:0] rd, output int lat);
      logic [31:0] off;
      int          nb;
      logic        io;
      off = a - BASE;
      nb  = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
      io  = 1'b0;
`ifdef CPU_LSU_MMIO_EN
      io  = (a >= 32'hFFFF_0000);
`endif
      e  = (sz == 2'd3) || ((a[1:0] & 2'(nb - 1)) != 2'd0) || (!io && off >= RAM_BYTES);
      rd = 32'd0;
      lat = 1;
      if (e) return;
      if (io) begin
         lat = 2;
         return;
      end
      if (we) begin
         for (int i = 0; i < nb; i++) mref[off + 32'(i)] = wd[8*i +: 8];
         lat = (nb == 4) ? 2 : 4;
      end else begin
         for (int i = 0; i < nb; i++) rd[8*i +: 8] = mbyte(off + 32'(i));
         if (!uns && nb < 4 && rd[8*nb-1]) rd = rd | ~((32'd1 << (8*nb)) - 32'd1);
         lat = 3;
      end
   endfunction

   // Issue one request; lat counts cycles from the accept edge to the response cycle.
   task automatic do_req(input logic we, input logic [1:0] sz, input logic uns,
                         input logic [31:0] a, input logic [31:0] wd,
                         output logic e, output logic [31:0] rd, output int lat);
      int n;
      @(negedge clk);
      req_valid = 1'b1; req_we = we; req_size = sz; req_unsigned = uns;
      req_addr = a; req_wdata = wd;
      n = 0;
      while (!req_ready && n < 20) begin
         @(negedge clk);
         n++;
      end
      @(posedge clk);
      #1;
      req_valid = 1'b0; req_we = 1'($urandom); req_size = 2'($urandom);
      req_unsigned = 1'($urandom); req_addr = $urandom; req_wdata = $urandom;
      lat = 0;
      do begin
         @(negedge clk);
         lat++;
      end while (!resp_valid && lat < 20);
      e  = resp_err;
      rd = resp_rdata;
      if (!resp_valid) begin
         n_tests++;
         n_fail++;
         $display("FAIL resp_timeout: got no resp_valid after %0d cycles, required one", lat);
         lat = -1;
         return;
      end
      chk("ready_low_in_resp", {31'd0, req_ready}, 32'd0);
      @(negedge clk);
      chk("resp_one_cycle", {31'd0, resp_valid}, 32'd0);
      chk("ready_after_resp", {31'd0, req_ready}, 32'd1);
      chk("rdata_held", resp_rdata, rd);
   endtask

   task automatic run_model(input string tag, input logic we, input logic [1:0] sz, input logic uns,
                            input logic [31:0] a, input logic [31:0] wd);
      logic        e_exp, e_act;
      logic [31:0] r_exp, r_act;
      int          l_exp, l_act;
      model_op(we, sz, uns, a, wd, e_exp, r_exp, l_exp);
      do_req(we, sz, uns, a, wd, e_act, r_act, l_act);
      chk({tag, "_err"}, {31'd0, e_act}, {31'd0, e_exp});
      chk({tag, "_rdata"}, r_act, r_exp);
      chk({tag, "_lat"}, l_act, l_exp);
   endtask

   typedef struct {
      logic        we;
      logic [1:0]  sz;
      logic        uns;
      logic [31:0] addr;
      logic [31:0] wd;
      logic        err;
      logic [31:0] rd;
      int          lat;
   } vec_t;

   vec_t vt [18];

   initial begin
      logic        e, me;
      logic [31:0] rd, mrd, mw;
      int          lat, mlat, r0, w0, e0, io_cyc;

      for (int i = 0; i < (1 << AW); i++) ram[i] = 32'h0;

      vt[0]  = '{1'b1, 2'd2, 1'b0, 32'h1000_0004, 32'h1234_5678, 1'b0, 32'h0000_0000, 2};
      vt[1]  = '{1'b0, 2'd2, 1'b0, 32'h1000_0004, 32'h0,         1'b0, 32'h1234_5678, 3};
      vt[2]  = '{1'b1, 2'd2, 1'b0, 32'h1000_0000, 32'h8081_8283, 1'b0, 32'h0000_0000, 2};
      vt[3]  = '{1'b0, 2'd0, 1'b0, 32'h1000_0001, 32'h0,         1'b0, 32'hFFFF_FF82, 3};
      vt[4]  = '{1'b0, 2'd0, 1'b1, 32'h1000_0001, 32'h0,         1'b0, 32'h0000_0082, 3};
      vt[5]  = '{1'b0, 2'd1, 1'b0, 32'h1000_0002, 32'h0,         1'b0, 32'hFFFF_8081, 3};
      vt[6]  = '{1'b0, 2'd1, 1'b1, 32'h1000_0002, 32'h0,         1'b0, 32'h0000_8081, 3};
      vt[7]  = '{1'b0, 2'd2, 1'b0, 32'h1000_0002, 32'h0,         1'b1, 32'h0000_0000, 1};
      vt[8]  = '{1'b1, 2'd1, 1'b0, 32'h1000_0001, 32'h0000_1234, 1'b1, 32'h0000_0000, 1};
      vt[9]  = '{1'b0, 2'd2, 1'b0, 32'h0FFF_FFFC, 32'h0,         1'b1, 32'h0000_0000, 1};
      vt[10] = '{1'b0, 2'd3, 1'b0, 32'h1000_0000, 32'h0,         1'b1, 32'h0000_0000, 1};
      vt[11] = '{1'b0, 2'd2, 1'b0, 32'h1000_FFFC, 32'h0,         1'b0, 32'h0000_0000, 3};
      vt[12] = '{1'b0, 2'd2, 1'b0, 32'h1001_0000, 32'h0,         1'b1, 32'h0000_0000, 1};
      vt[13] = '{1'b1, 2'd0, 1'b0, 32'h1000_0003, 32'h1234_56FF, 1'b0, 32'h0000_0000, 4};
      vt[14] = '{1'b0, 2'd2, 1'b0, 32'h1000_0000, 32'h0,         1'b0, 32'hFF81_8283, 3};
      vt[15] = '{1'b1, 2'd1, 1'b0, 32'h1000_0006, 32'hBEEF_CAFE, 1'b0, 32'h0000_0000, 4};
      vt[16] = '{1'b0, 2'd2, 1'b0, 32'h1000_0004, 32'h0,         1'b0, 32'hCAFE_5678, 3};
      vt[17] = '{1'b0, 2'd1, 1'b0, 32'h1000_0006, 32'h0,         1'b0, 32'hFFFF_CAFE, 3};

      repeat (3) @(negedge clk);
      chk("rst_req_ready", {31'd0, req_ready}, 32'd1);
      chk("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
      chk("rst_resp_err", {31'd0, resp_err}, 32'd0);
      chk("rst_resp_rdata", resp_rdata, 32'd0);
      chk("rst_mem_en", {31'd0, mem_en}, 32'd0);
      chk("rst_mem_we", {31'd0, mem_we}, 32'd0);
      chk("rst_mem_addr", 32'(mem_addr), 32'd0);
      chk("rst_mem_wdata", mem_wdata, 32'd0);
      rst = 1'b1;

      for (int i = 0; i < 18; i++) begin
         e0 = en_cnt;
         do_req(vt[i].we, vt[i].sz, vt[i].uns, vt[i].addr, vt[i].wd, e, rd, lat);
         model_op(vt[i].we, vt[i].sz, vt[i].uns, vt[i].addr, vt[i].wd, me, mrd, mlat);
         chk($sformatf("vec%0d_err", i), {31'd0, e}, {31'd0, vt[i].err});
         chk($sformatf("vec%0d_rdata", i), rd, vt[i].rd);
         chk($sformatf("vec%0d_lat", i), lat, vt[i].lat);
         if (vt[i].err) chk($sformatf("vec%0d_no_mem_en", i), en_cnt - e0, 32'd0);
      end

      // Sub-word store: one read, one write of the spliced word.
      run_model("sw_rmw_base", 1'b1, 2'd2, 1'b0, 32'h1000_0008, 32'h1122_3344);
      r0 = rd_cnt;
      w0 = wr_cnt;
      do_req(1'b1, 2'd0, 1'b0, 32'h1000_000A, 32'h0000_00AB, e, rd, lat);
      model_op(1'b1, 2'd0, 1'b0, 32'h1000_000A, 32'h0000_00AB, me, mrd, mlat);
      chk("sb_lat", lat, 32'd4);
      chk("sb_reads", rd_cnt - r0, 32'd1);
      chk("sb_writes", wr_cnt - w0, 32'd1);
      chk("sb_wdata", last_wr, 32'h11AB_3344);
      chk("sb_ram", ram[2], 32'h11AB_3344);

      // Reset during MERGE of a sub-word store drops the store.
      run_model("rst_base", 1'b1, 2'd2, 1'b0, 32'h1000_000C, 32'h5566_7788);
      w0 = wr_cnt;
      @(negedge clk);
      req_valid = 1'b1; req_we = 1'b1; req_size = 2'd0; req_unsigned = 1'b0;
      req_addr = 32'h1000_000C; req_wdata = 32'h0000_0099;
      chk("rst_pre_ready", {31'd0, req_ready}, 32'd1);
      @(posedge clk);
      #1 req_valid = 1'b0;
      @(posedge clk);
      #2 rst = 1'b0;
      #1;
      chk("rst_mid_ready", {31'd0, req_ready}, 32'd1);
      chk("rst_mid_mem_en", {31'd0, mem_en}, 32'd0);
      chk("rst_mid_mem_we", {31'd0, mem_we}, 32'd0);
      chk("rst_mid_resp", {31'd0, resp_valid}, 32'd0);
      repeat (2) @(negedge clk);
      rst = 1'b1;
      repeat (3) @(negedge clk);
      chk("rst_no_write", wr_cnt - w0, 32'd0);
      chk("rst_ram_kept", ram[3], 32'h5566_7788);
      run_model("rst_reload", 1'b0, 2'd2, 1'b0, 32'h1000_000C, 32'h0);

`ifdef CPU_LSU_MMIO_EN
      io_ready = 1'b0;
      io_cyc = 0;
      fork
         do_req(1'b0, 2'd2, 1'b0, 32'hFFFF_0004, 32'h0, e, rd, lat);
         for (int k = 0; k < 30; k++) begin
            @(negedge clk);
            if (io_valid) begin
               io_cyc++;
               if (io_cyc == 6) begin
                  io_ready = 1'b1;
                  io_rdata = 32'h0000_0041;
               end
            end
         end
      join
      chk("io_valid_cycles", io_cyc, 32'd6);
      chk("io_err", {31'd0, e}, 32'd0);
      chk("io_rdata", rd, 32'h0000_0041);
      chk("io_lat", lat, 32'd7);
      io_rdata = 32'h0;
`endif

      for (int i = 0; i < 300; i++) begin
         int unsigned r;
         logic [31:0] a;
         r = $urandom_range(0, 9);
         if (r == 0)      a = $urandom;
         else if (r == 1) a = BASE + 32'hFFF8 + 32'($urandom_range(0, 15));
         else             a = BASE + 32'($urandom_range(0, 63));
         run_model($sformatf("rnd%0d", i), 1'($urandom), 2'($urandom_range(0, 3)),
                   1'($urandom), a, $urandom);
      end

      for (int w = 0; w < 16; w++) begin
         mw = {mbyte(32'(4*w+3)), mbyte(32'(4*w+2)), mbyte(32'(4*w+1)), mbyte(32'(4*w))};
         chk($sformatf("ram_word%0d", w), ram[w], mw);
      end
      for (int w = (1 << AW) - 2; w < (1 << AW); w++) begin
         mw = {mbyte(32'(4*w+3)), mbyte(32'(4*w+2)), mbyte(32'(4*w+1)), mbyte(32'(4*w))};
         chk($sformatf("ram_word%0d", w), ram[w], mw);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
